// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order WB stream vs. buffered long-latency results.
// Optional same-cycle LL bypass into an empty FIFO when WBARB_LL_BYPASS_EN is defined.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4:0]               wb_wd,
    input  logic                     wb_wreg,
    input  logic [31:0]              wb_wdata,
    input  logic                     ll_valid,
    input  logic [4:0]               ll_wd,
    input  logic [31:0]              ll_wdata,
    output logic                     ll_ready,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   ll_pending
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0]    age_q, age_d;
    logic [4:0]    memWd_q   [DEPTH];
    logic [31:0]   memData_q [DEPTH];
    logic          rfWe_q, rfWe_d;
    logic [4:0]    rfWaddr_q, rfWaddr_d;
    logic [31:0]   rfWdata_q, rfWdata_d;

    logic          empty, full, forced, push, pop;
    logic          grantPipe, grantLl, grantByp;
    logic [4:0]    selWd;
    logic [31:0]   selData;

    assign empty      = (wptr_q == rptr_q);
    assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign forced     = !empty && (age_q >= MaxWait);
    assign ll_pending = wptr_q - rptr_q;
    assign ll_ready   = rst && !full;
    assign stall_req  = rst && forced;

    // Aged FIFO head beats the pipeline; otherwise the pipeline wins and LL fills idle slots.
    always_comb begin
        grantPipe = 1'b0;
        grantLl   = 1'b0;
        grantByp  = 1'b0;
        if (forced) begin
            grantLl = 1'b1;
        end else if (wb_wreg) begin
            grantPipe = 1'b1;
        end else if (!empty) begin
            grantLl = 1'b1;
`ifdef WBARB_LL_BYPASS_EN
        end else if (ll_valid) begin
            grantByp = 1'b1;
`endif
        end
    end

    assign pop  = grantLl;
    assign push = ll_valid && ll_ready && !grantByp;

    always_comb begin
        selWd   = wb_wd;
        selData = wb_wdata;
        if (grantLl) begin
            selWd   = memWd_q[rptr_q[AW-1:0]];
            selData = memData_q[rptr_q[AW-1:0]];
        end else if (grantByp) begin
            selWd   = ll_wd;
            selData = ll_wdata;
        end
    end

    always_comb begin
        wptr_d    = push ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d    = pop  ? rptr_q + (AW+1)'(1) : rptr_q;
        age_d     = age_q;
        if (pop) begin
            age_d = 4'd0;
        end else if (grantPipe && !empty && (age_q < MaxWait)) begin
            age_d = age_q + 4'd1;
        end
        rfWe_d    = (grantPipe || grantLl || grantByp) && (selWd != 5'd0);
        rfWaddr_d = rfWe_d ? selWd   : rfWaddr_q;
        rfWdata_d = rfWe_d ? selData : rfWdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            age_q     <= 4'd0;
            rfWe_q    <= 1'b0;
            rfWaddr_q <= 5'd0;
            rfWdata_q <= 32'd0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            age_q     <= age_d;
            rfWe_q    <= rfWe_d;
            rfWaddr_q <= rfWaddr_d;
            rfWdata_q <= rfWdata_d;
        end
    end

    // Storage needs no reset: occupancy is defined solely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            memWd_q[wptr_q[AW-1:0]]   <= ll_wd;
            memData_q[wptr_q[AW-1:0]] <= ll_wdata;
        end
    end

    assign rf_we    = rfWe_q;
    assign rf_waddr = rfWaddr_q;
    assign rf_wdata = rfWdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: reset, directed vector table, idle LL latency,
// randomized traffic against a queue-based reference model, and async reset mid-stream.
module tb_wb_port_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        ll_valid;
    logic [4:0]  ll_wd;
    logic [31:0] ll_wdata;
    logic        ll_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic [1:0]  ll_pending;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .ll_valid(ll_valid), .ll_wd(ll_wd), .ll_wdata(ll_wdata),
        .ll_ready(ll_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_req(stall_req), .ll_pending(ll_pending)
    );

    typedef struct {
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        llv;
        logic [4:0]  llwd;
        logic [31:0] lldata;
        logic        eStall;
        logic        eReady;
        logic [1:0]  ePend;
        logic        eWe;
        logic [4:0]  eAddr;
        logic [31:0] eData;
    } vec_t;

    typedef struct {
        logic [4:0]  wd;
        logic [31:0] data;
    } llEntry_t;

    vec_t     vecs[$];
    llEntry_t mq[$];
    int       mAge;
    logic     mForced;

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(logic wreg, logic [4:0] wd, logic [31:0] wdata,
                                 logic llv, logic [4:0] llwd, logic [31:0] lldata);
        wb_wreg  = wreg;
        wb_wd    = wd;
        wb_wdata = wdata;
        ll_valid = llv;
        ll_wd    = llwd;
        ll_wdata = lldata;
    endtask

    task automatic addVec(logic wreg, logic [4:0] wd, logic [31:0] wdata,
                          logic llv, logic [4:0] llwd, logic [31:0] lldata,
                          logic eStall, logic eReady, logic [1:0] ePend,
                          logic eWe, logic [4:0] eAddr, logic [31:0] eData);
        vec_t v;
        v = '{wreg, wd, wdata, llv, llwd, lldata, eStall, eReady, ePend, eWe, eAddr, eData};
        vecs.push_back(v);
    endtask

    task automatic doReset();
        rst = 1'b0;
        applyStimulus(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd4, 32'h2222_2222);
        mq.delete();
        mAge = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("reset ll_ready", {31'd0, ll_ready}, 32'd0);
        checkOutput("reset stall_req", {31'd0, stall_req}, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #3 rst = 1'b1;
        #1;
        checkOutput("post-reset ll_ready", {31'd0, ll_ready}, 32'd1);
        checkOutput("post-reset ll_pending", {30'd0, ll_pending}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // One cycle with the reference model: rules are applied to a queue of buffered results.
    task automatic modelCycle(string tag);
        int       kind;
        logic     eWe;
        logic     doPush;
        logic     wasNonEmpty;
        llEntry_t e;
        logic [4:0]  selWd;
        logic [31:0] selData;

        wasNonEmpty = (mq.size() > 0);
        mForced     = wasNonEmpty && (mAge >= MAX_WAIT);
        #1;
        checkOutput({tag, " stall_req"}, {31'd0, stall_req}, {31'd0, mForced});
        checkOutput({tag, " ll_ready"}, {31'd0, ll_ready}, (mq.size() < DEPTH) ? 32'd1 : 32'd0);
        checkOutput({tag, " ll_pending"}, {30'd0, ll_pending}, mq.size());

        kind    = 0;
        selWd   = 5'd0;
        selData = 32'd0;
        if (mForced || (!wb_wreg && wasNonEmpty)) begin
            kind    = 2;
            selWd   = mq[0].wd;
            selData = mq[0].data;
        end else if (wb_wreg) begin
            kind    = 1;
            selWd   = wb_wd;
            selData = wb_wdata;
        end
`ifdef WBARB_LL_BYPASS_EN
        else if (ll_valid) begin
            kind    = 3;
            selWd   = ll_wd;
            selData = ll_wdata;
        end
`endif
        doPush = ll_valid && (mq.size() < DEPTH) && (kind != 3);
        e.wd   = ll_wd;
        e.data = ll_wdata;
        if (kind == 2) begin
            void'(mq.pop_front());
            mAge = 0;
        end else if (kind == 1 && wasNonEmpty && mAge < MAX_WAIT) begin
            mAge++;
        end
        if (doPush) mq.push_back(e);
        eWe = (kind != 0) && (selWd != 5'd0);

        @(posedge clk);
        #1;
        checkOutput({tag, " rf_we"}, {31'd0, rf_we}, {31'd0, eWe});
        if (eWe) begin
            checkOutput({tag, " rf_waddr"}, {27'd0, rf_waddr}, {27'd0, selWd});
            checkOutput({tag, " rf_wdata"}, rf_wdata, selData);
        end
    endtask

    initial begin
        // Reset with active inputs
        doReset();

        // Directed vectors: starvation, full FIFO, register $0 filtering
        addVec(1, 5'd1,  32'hA1,   1, 5'd7,  32'h77,   0, 1, 2'd0, 1, 5'd1,  32'hA1);
        addVec(1, 5'd2,  32'hA2,   0, 5'd0,  32'h0,    0, 1, 2'd1, 1, 5'd2,  32'hA2);
        addVec(1, 5'd3,  32'hA3,   0, 5'd0,  32'h0,    0, 1, 2'd1, 1, 5'd3,  32'hA3);
        addVec(1, 5'd4,  32'hA4,   0, 5'd0,  32'h0,    0, 1, 2'd1, 1, 5'd4,  32'hA4);
        addVec(1, 5'd5,  32'hA5,   0, 5'd0,  32'h0,    0, 1, 2'd1, 1, 5'd5,  32'hA5);
        addVec(1, 5'd6,  32'hA6,   0, 5'd0,  32'h0,    1, 1, 2'd1, 1, 5'd7,  32'h77);
        addVec(1, 5'd6,  32'hA6,   0, 5'd0,  32'h0,    0, 1, 2'd0, 1, 5'd6,  32'hA6);
        addVec(1, 5'd8,  32'hA8,   1, 5'd9,  32'h99,   0, 1, 2'd0, 1, 5'd8,  32'hA8);
        addVec(1, 5'd10, 32'hAA,   1, 5'd11, 32'hBB,   0, 1, 2'd1, 1, 5'd10, 32'hAA);
        addVec(1, 5'd12, 32'hAC,   1, 5'd13, 32'hDD,   0, 0, 2'd2, 1, 5'd12, 32'hAC);
        addVec(0, 5'd0,  32'h0,    1, 5'd13, 32'hDD,   0, 0, 2'd2, 1, 5'd9,  32'h99);
        addVec(0, 5'd0,  32'h0,    1, 5'd13, 32'hDD,   0, 1, 2'd1, 1, 5'd11, 32'hBB);
        addVec(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 1, 2'd1, 1, 5'd13, 32'hDD);
        addVec(1, 5'd0,  32'h1234, 1, 5'd0,  32'h5555, 0, 1, 2'd0, 0, 5'd0,  32'h0);
        addVec(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 1, 2'd1, 0, 5'd0,  32'h0);
        addVec(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 1, 2'd0, 0, 5'd0,  32'h0);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].wreg, vecs[i].wd, vecs[i].wdata,
                          vecs[i].llv, vecs[i].llwd, vecs[i].lldata);
            #1;
            checkOutput({tag, " stall_req"}, {31'd0, stall_req}, {31'd0, vecs[i].eStall});
            checkOutput({tag, " ll_ready"}, {31'd0, ll_ready}, {31'd0, vecs[i].eReady});
            checkOutput({tag, " ll_pending"}, {30'd0, ll_pending}, {30'd0, vecs[i].ePend});
            @(posedge clk);
            #1;
            checkOutput({tag, " rf_we"}, {31'd0, rf_we}, {31'd0, vecs[i].eWe});
            if (vecs[i].eWe) begin
                checkOutput({tag, " rf_waddr"}, {27'd0, rf_waddr}, {27'd0, vecs[i].eAddr});
                checkOutput({tag, " rf_wdata"}, rf_wdata, vecs[i].eData);
            end
        end

        // Idle LL path latency
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifdef WBARB_LL_BYPASS_EN
        checkOutput("idle-ll rf_we", {31'd0, rf_we}, 32'd1);
        checkOutput("idle-ll rf_waddr", {27'd0, rf_waddr}, 32'd5);
        checkOutput("idle-ll rf_wdata", rf_wdata, 32'hDEAD_BEEF);
        checkOutput("idle-ll ll_pending", {30'd0, ll_pending}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("idle-ll rf_we drop", {31'd0, rf_we}, 32'd0);
`else
        checkOutput("idle-ll rf_we early", {31'd0, rf_we}, 32'd0);
        checkOutput("idle-ll ll_pending", {30'd0, ll_pending}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("idle-ll rf_we", {31'd0, rf_we}, 32'd1);
        checkOutput("idle-ll rf_waddr", {27'd0, rf_waddr}, 32'd5);
        checkOutput("idle-ll rf_wdata", rf_wdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        checkOutput("idle-ll rf_we drop", {31'd0, rf_we}, 32'd0);
`endif

        // Randomized traffic against the reference model; WB inputs held after a stall
        doReset();
        mForced = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!mForced) begin
                wb_wreg  = ($urandom_range(0, 9) < 6);
                wb_wd    = 5'($urandom_range(0, 31));
                wb_wdata = $urandom;
            end
            ll_valid = ($urandom_range(0, 1) == 1);
            ll_wd    = 5'($urandom_range(0, 31));
            ll_wdata = $urandom;
            modelCycle($sformatf("rand%0d", n));
        end

        // Async reset with two results buffered
        doReset();
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd20, 32'h2020);
        modelCycle("fill0");
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd21, 32'h2121);
        modelCycle("fill1");
        #1;
        checkOutput("fill ll_pending", {30'd0, ll_pending}, 32'd2);
        checkOutput("fill ll_ready", {31'd0, ll_ready}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("async rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("async rf_waddr", {27'd0, rf_waddr}, 32'd0);
        checkOutput("async rf_wdata", rf_wdata, 32'd0);
        checkOutput("async ll_pending", {30'd0, ll_pending}, 32'd0);
        checkOutput("async ll_ready", {31'd0, ll_ready}, 32'd0);
        checkOutput("async stall_req", {31'd0, stall_req}, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("post-async%0d rf_we", k), {31'd0, rf_we}, 32'd0);
            checkOutput($sformatf("post-async%0d ll_pending", k), {30'd0, ll_pending}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - the in-order writeback stream from the MEM/WB pipeline register;
  - a long-latency unit (divider, multi-cycle ops) that returns results out of band.
- Buffers long-latency results in a small FIFO and grants them the port on idle WB cycles.
- Forces a one-cycle pipeline stall when a buffered result has waited too long.
- Sits between the MEM/WB register and the register file.

Parameters:
- DEPTH, 2, long-latency result FIFO entries; power of two, ≥2.
- MAX_WAIT, 4, cycles the FIFO head may be bypassed by pipeline writes before it is forced through; range 1–15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- wb_wd  input  5  pipeline WB destination register.
- wb_wreg  input  1  pipeline WB write enable.
- wb_wdata  input  32  pipeline WB data.
- ll_valid  input  1  long-latency result valid.
- ll_wd  input  5  long-latency destination register.
- ll_wdata  input  32  long-latency result data.
- ll_ready  output  1  FIFO can accept; transfer occurs when ll_valid && ll_ready.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  5  register-file write address (registered).
- rf_wdata  output  32  register-file write data (registered).
- stall_req  output  1  combinational; freezes pipeline so WB inputs are held next cycle.
- ll_pending  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst low, asynchronous):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO emptied, ll_pending=0, age counter=0.
  - stall_req=0 and ll_ready=0 while rst is low.
- After reset deasserts: ll_ready = !full.
- FIFO: circular buffer with read/write pointers one bit wider than the index; full when the MSBs differ and the indices are equal.
  - Push on ll_valid && ll_ready.
  - Pop on LL grant.
  - Push and pop may occur in the same cycle when not full.
  - When full, ll_ready=0 even if a pop occurs this cycle.
- Grant decision, evaluated every cycle, priority order:
  1. FIFO non-empty and age ≥ MAX_WAIT → LL grant; stall_req=1 this cycle; pipeline WB is not written and is re-presented next cycle.
  2. wb_wreg=1 → pipeline grant; stall_req=0.
  3. FIFO non-empty → LL grant.
  4. Otherwise idle; rf_we=0 next cycle.
- Latency: the granted write appears on rf_* on the next rising edge, held for exactly one cycle.
  - A pushed LL result can be granted no earlier than the cycle after its push (min 2 cycles from ll_valid to rf_we), unless the optional feature is enabled.
- Register $0: any granted write with destination 0 yields rf_we=0.
  - It still consumes the grant, pops the FIFO if LL, and clears age.
- Age counter:
  - Increments (saturating at MAX_WAIT) on each pipeline grant while the FIFO is non-empty.
  - Clears on every pop.
  - Holds when the FIFO is empty.
- stall_req is never asserted for two consecutive cycles: age clears on pop, and MAX_WAIT ≥ 1.
- Reset mid-operation: all buffered LL results are discarded and no write is issued.

Optional Feature:
- Macro: WBARB_LL_BYPASS_EN.
- Defined: when the FIFO is empty, wb_wreg=0 and ll_valid=1, the incoming LL result is granted in the same cycle without being pushed. rf_we follows on the next edge (1-cycle latency), and ll_pending stays 0.
- Undefined: every LL result passes through the FIFO (min 2-cycle latency).

Test Plan:
1. Reset: hold rst=0 with ll_valid=1, wb_wreg=1 → rf_we=0, ll_ready=0, stall_req=0; release → ll_ready=1, ll_pending=0.
2. Idle LL path: ll_valid=1, ll_wd=5, ll_wdata=0xDEADBEEF for 1 cycle, wb_wreg=0 → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF exactly 2 cycles later (1 cycle with WBARB_LL_BYPASS_EN).
3. Starvation (MAX_WAIT=4): push one LL result to r7, then drive wb_wreg=1 every cycle → 4 pipeline writes, then stall_req=1 for one cycle and rf_waddr=7 next; the held WB write follows the cycle after.
4. Full FIFO (DEPTH=2): push 2 results while wb_wreg=1 → ll_pending=2, ll_ready=0; a third ll_valid is not accepted until a pop.
5. $0 filter: pipeline write wb_wd=0, wb_wdata=0x1234 and LL write ll_wd=0 → rf_we stays 0; LL entry is still popped, ll_pending returns to 0.
6. Async reset with ll_pending=2 mid-stream → outputs clear immediately, without waiting for a clk edge; after release no stale write appears on rf_*.
